// File: rtl/button_conditioner.sv
// Conditions the active-low Run/Continue push-buttons: two-flop synchronizer, counter debouncer,
// registered one-cycle press pulses, and a two-button chord presented as a reset request.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Run_n,
   input  logic Continue_n,
   output logic Run_level,
   output logic Continue_level,
   output logic Run_pulse,
   output logic Continue_pulse,
   output logic Reset_req
);

   typedef enum logic {IDLE, CHORD} chord_state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Bit 0 is Run, bit 1 is Continue throughout.
   logic [1:0]       btn;
   logic [1:0]       sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];
   logic [1:0]       db_q, db_d;
   logic [1:0]       pulse_q, pulse_d;
   logic             reset_req_q, reset_req_d;
   chord_state_t     state_q, state_d;

   assign btn = {~Continue_n, ~Run_n};

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
         db_d[i]  = db_q[i];
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            db_d[i]  = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   // Chord tracking and pulse qualification both look at the next debounced levels,
   // so pulses and Reset_req change on the same edge as the levels.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (db_d[0] & db_d[1])   state_d = CHORD;
         CHORD:   if (~db_d[0] & ~db_d[1]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      pulse_d[0]  = db_d[0] & ~db_q[0] & ~db_d[1] & (state_q == IDLE);
      pulse_d[1]  = db_d[1] & ~db_q[1] & ~db_d[0] & (state_q == IDLE);
      reset_req_d = db_d[0] & db_d[1];
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         db_q        <= '0;
         pulse_q     <= '0;
         reset_req_q <= 1'b0;
         state_q     <= IDLE;
         // NOTE: the small counter array is reset explicitly; a partial count must not survive reset.
         for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q     <= btn;
         sync2_q     <= sync1_q;
         db_q        <= db_d;
         pulse_q     <= pulse_d;
         reset_req_q <= reset_req_d;
         state_q     <= state_d;
         for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign Run_level      = db_q[0];
   assign Continue_level = db_q[1];
   assign Run_pulse      = pulse_q[0];
   assign Continue_pulse = pulse_q[1];
   assign Reset_req      = reset_req_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4; every cycle's outputs are
// compared against hand-derived expectations packed as {Run_level, Continue_level, Run_pulse, Continue_pulse, Reset_req}.
module tb_button_conditioner;

   localparam int DEB = 4;

   logic Clk = 1'b0;
   logic Reset, Run_n, Continue_n;
   logic Run_level, Continue_level, Run_pulse, Continue_pulse, Reset_req;

   int vectors     = 0;
   int miscompares = 0;

   button_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .Run_n          (Run_n),
      .Continue_n     (Continue_n),
      .Run_level      (Run_level),
      .Continue_level (Continue_level),
      .Run_pulse      (Run_pulse),
      .Continue_pulse (Continue_pulse),
      .Reset_req      (Reset_req)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] obs();
      return {Run_level, Continue_level, Run_pulse, Continue_pulse, Reset_req};
   endfunction

   function automatic logic [4:0] ev(input bit rl, input bit cl, input bit rp,
                                     input bit cp, input bit rr);
      return {rl, cl, rp, cp, rr};
   endfunction

   // Advance through one rising edge and settle away from it.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset      = 1'b1;
      Run_n      = 1'b1;
      Continue_n = 1'b1;

      // Reset held 3 cycles, then 20 idle cycles.
      for (int e = 0; e < 3; e++) begin
         tick();
         check($sformatf("reset e%0d", e), obs(), ev(0, 0, 0, 0, 0));
      end
      Reset = 1'b0;
      for (int e = 0; e < 20; e++) begin
         tick();
         check($sformatf("idle e%0d", e), obs(), ev(0, 0, 0, 0, 0));
      end

      // Single Run press: level after edge 5, pulse only on edge 5.
      Run_n = 1'b0;
      for (int e = 0; e < 10; e++) begin
         tick();
         check($sformatf("run_press e%0d", e), obs(), ev(e >= 5, 0, e == 5, 0, 0));
      end
      Run_n = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         check($sformatf("run_release e%0d", e), obs(), ev(e < 5, 0, 0, 0, 0));
      end

      // Bounce: low 3, high 1, low 3, then high; never qualifies.
      for (int e = 0; e < 15; e++) begin
         Run_n = (e == 3 || e >= 7);
         tick();
         check($sformatf("bounce e%0d", e), obs(), ev(0, 0, 0, 0, 0));
      end
      Run_n = 1'b1;

      // Simultaneous chord held 10 cycles, then released.
      for (int e = 0; e < 20; e++) begin
         Run_n      = (e >= 10);
         Continue_n = (e >= 10);
         tick();
         check($sformatf("chord e%0d", e), obs(),
               ev(e >= 5 && e < 15, e >= 5 && e < 15, 0, 0, e >= 5 && e < 15));
      end

      // Continue, then Run joins, Continue released and re-pressed while Run held.
      for (int e = 0; e < 40; e++) begin
         Continue_n = (e >= 20 && e < 30);
         Run_n      = (e < 10);
         tick();
         check($sformatf("seq e%0d", e), obs(),
               ev(e >= 15, (e >= 5 && e < 25) || e >= 35, 0, e == 5,
                  (e >= 15 && e < 25) || e >= 35));
      end
      Run_n      = 1'b1;
      Continue_n = 1'b1;
      Reset      = 1'b1;
      tick();
      check("seq_cleanup_reset", obs(), ev(0, 0, 0, 0, 0));
      tick();
      Reset = 1'b0;

      // Button held across a mid-count reset: only the post-reset press pulses.
      tick();
      tick();
      Run_n = 1'b0;
      for (int e = 0; e < 4; e++) begin
         tick();
         check($sformatf("pre_reset e%0d", e), obs(), ev(0, 0, 0, 0, 0));
      end
      Reset = 1'b1;
      tick();
      check("mid_count_reset", obs(), ev(0, 0, 0, 0, 0));
      Reset = 1'b0;
      for (int e = 0; e < 9; e++) begin
         tick();
         check($sformatf("post_reset e%0d", e), obs(), ev(e >= 5, 0, e == 5, 0, 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
